score_event_arbiter: RTL

- Collects per-lane hit/miss events from LANES hit-scanning lanes and serialises them, one per cycle, onto one shared BCD update datapath.
- Maintains the global BCD score, hit count, miss count and combo streak that feed the display/scoreboard logic.
- Uses round-robin arbitration so simultaneous lane events are never lost and no lane is starved.

---
 rtl/score_event_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/score_event_arbiter.sv
// score_event_arbiter: collects per-lane hit/miss events into one pending slot
// per lane, serialises them round-robin through a one-entry stage register and
// commits one event per cycle into saturating 4-digit BCD counters.
// Ports:
//   clk, n_rst          clock, async active-low reset
//   clear               synchronous clear of all state (new song)
//   lane_evt/hit/acc    per-lane event strobe, outcome and 3-bit accuracy
//   score, num_hits,    BCD counters (saturate at 9999)
//   num_misses, combo
//   update_valid        one-cycle pulse when the counters change
//   grant_lane          lane of the most recent committed update
//   busy                any pending or staged event
//   overrun             sticky: an event was dropped on a full slot
module score_event_arbiter #(
  parameter int unsigned LANES = 5
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic [LANES-1:0]     lane_evt,
  input  logic [LANES-1:0]     lane_hit,
  input  logic [3*LANES-1:0]   lane_acc,
  output logic [15:0]          score,
  output logic [15:0]          num_hits,
  output logic [15:0]          num_misses,
  output logic [15:0]          combo,
  output logic                 update_valid,
  output logic [2:0]           grant_lane,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned IW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BCD_W = 16;

  typedef struct packed {
    logic       hit;
    logic [2:0] acc;
  } evt_t;

  logic [LANES-1:0] slot_vld_q, slot_vld_d;
  evt_t             slot_q [LANES];
  evt_t             slot_d [LANES];
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             stg_vld_q, stg_vld_d;
  logic [IW-1:0]    stg_lane_q, stg_lane_d;
  evt_t             stg_q, stg_d;
  logic [BCD_W-1:0] score_q, score_d, hits_q, hits_d;
  logic [BCD_W-1:0] misses_q, misses_d, combo_q, combo_d;
  logic             uv_q, uv_d;
  logic [2:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;

  // Saturating BCD add of a single digit (0..9); a carry out of the top digit
  // means the true sum exceeds 9999.
  function automatic logic [BCD_W-1:0] bcd_add(input logic [BCD_W-1:0] a,
                                               input logic [3:0] inc);
    logic [BCD_W-1:0] r;
    logic [4:0]       d;
    logic             cy;
    r  = '0;
    cy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, a[4*k +: 4]} + ((k == 0) ? {1'b0, inc} : {4'b0, cy});
      if (d > 5'd9) begin
        d  = d - 5'd10;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      r[4*k +: 4] = d[3:0];
    end
    return cy ? 16'h9999 : r;
  endfunction

  // Round-robin search: first occupied slot at or above the pointer, wrapping.
  always_comb begin : arb
    int unsigned j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int unsigned k = 0; k < LANES; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= LANES) j = j - LANES;
      if (!gnt_vld && slot_vld_q[IW'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // Next-state for slots, stage, commit and status.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    ptr_d      = ptr_q;
    stg_vld_d  = gnt_vld;
    stg_lane_d = gnt_idx;
    stg_d      = slot_q[gnt_idx];
    score_d    = score_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    combo_d    = combo_q;
    uv_d       = stg_vld_q;
    grant_d    = grant_q;
    ovr_d      = ovr_q;

    if (gnt_vld) begin
      ptr_d = (gnt_idx == IW'(LANES - 1)) ? '0 : gnt_idx + IW'(1);
    end

    // A slot freed by this cycle's grant can accept a new event immediately.
    for (int unsigned i = 0; i < LANES; i++) begin
      if (gnt_vld && gnt_idx == IW'(i)) slot_vld_d[i] = 1'b0;
      if (lane_evt[i]) begin
        if (slot_vld_d[i]) begin
          ovr_d = 1'b1;
        end else begin
          slot_vld_d[i] = 1'b1;
          slot_d[i]     = '{hit: lane_hit[i], acc: lane_acc[3*i +: 3]};
        end
      end
    end

    if (stg_vld_q) begin
      grant_d = 3'(stg_lane_q);
      if (stg_q.hit) begin
        score_d = bcd_add(score_q, {1'b0, stg_q.acc});
        hits_d  = bcd_add(hits_q, 4'd1);
        combo_d = bcd_add(combo_q, 4'd1);
      end else begin
        misses_d = bcd_add(misses_q, 4'd1);
        combo_d  = '0;
      end
    end

    if (clear) begin
      slot_vld_d = '0;
      ptr_d      = '0;
      stg_vld_d  = 1'b0;
      score_d    = '0;
      hits_d     = '0;
      misses_d   = '0;
      combo_d    = '0;
      uv_d       = 1'b0;
      grant_d    = '0;
      ovr_d      = 1'b0;
    end

    busy_d = (|slot_vld_d) | stg_vld_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_vld_q <= '0;
      for (int i = 0; i < LANES; i++) slot_q[i] <= '0;
      ptr_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_lane_q <= '0;
      stg_q      <= '0;
      score_q    <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      combo_q    <= '0;
      uv_q       <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
      ptr_q      <= ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_lane_q <= stg_lane_d;
      stg_q      <= stg_d;
      score_q    <= score_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      combo_q    <= combo_d;
      uv_q       <= uv_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign score        = score_q;
  assign num_hits     = hits_q;
  assign num_misses   = misses_q;
  assign combo        = combo_q;
  assign update_valid = uv_q;
  assign grant_lane   = grant_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule
